// File: rtl/gat_feat_bram_reader.sv
// Feature BRAM drain engine: reads NUM words from the GAT core's new-feature
// BRAM once the core reports ready and streams them out over AXI-Stream.
// Reads are credit-limited so every returning word has a FIFO slot.
module gat_feat_bram_reader #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [NEW_FEATURE_ADDR_W:0]   i_num_words,
    input  logic                          i_gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] o_feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  i_feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  o_m_axis_tdata,
    output logic                          o_m_axis_tvalid,
    input  logic                          i_m_axis_tready,
    output logic                          o_m_axis_tlast,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int AW    = NEW_FEATURE_ADDR_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    // Wide enough for fifo_count + inflight without overflow.
    localparam int USE_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StIssue,
        StFlush,
        StDone
    } state_t;

    state_t                        r_state;
    logic [AW:0]                   r_num_words;
    logic [AW:0]                   r_rd_idx;
    logic [AW:0]                   r_out_cnt;
    logic [AW+1:0]                 r_addr_hold;
    logic                          r_busy;
    logic                          r_done;
    logic [RD_LATENCY-1:0]         r_pipe;

    logic [NEW_FEATURE_WIDTH-1:0]  r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              r_wr_ptr;
    logic [PTR_W-1:0]              r_rd_ptr;
    logic [CNT_W-1:0]              r_fifo_cnt;

    logic [USE_W-1:0]              w_inflight;
    logic [USE_W-1:0]              w_used;
    logic                          w_issue;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_tvalid;
    logic [AW+1:0]                 w_issue_addr;
    logic                          w_drained;

    // Count reads whose data has not yet reached the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + USE_W'(r_pipe[i]);
        end
    end

    // Credit check and handshake decode.
    always_comb begin
        w_used       = USE_W'(r_fifo_cnt) + w_inflight;
        w_issue      = (r_state == StIssue) && (w_used < USE_W'(FIFO_DEPTH))
                       && (r_rd_idx < r_num_words);
        w_push       = r_pipe[RD_LATENCY-1];
        w_tvalid     = (r_fifo_cnt != '0);
        w_pop        = w_tvalid && i_m_axis_tready;
        w_issue_addr = {r_rd_idx[AW-1:0], 2'b00};
        w_drained    = (w_inflight == '0) && (r_fifo_cnt == '0)
                       && (r_out_cnt == r_num_words);
    end

    // The address is presented in the issue cycle itself so the pipe only has
    // to cover the BRAM latency; otherwise the credit window cannot sustain
    // one beat per cycle with a FIFO of RD_LATENCY+2 entries.
    assign o_feat_bram_addrb = w_issue ? w_issue_addr : r_addr_hold;
    assign o_m_axis_tvalid   = w_tvalid;
    assign o_m_axis_tdata    = w_tvalid ? r_fifo_mem[r_rd_ptr] : '0;
    assign o_m_axis_tlast    = w_tvalid && (r_out_cnt == r_num_words - 1'b1);
    assign o_busy            = r_busy;
    assign o_done            = r_done;

    // Control FSM with read index, beat counter and registered busy/done.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_num_words <= '0;
            r_rd_idx    <= '0;
            r_out_cnt   <= '0;
            r_addr_hold <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_issue) begin
                r_rd_idx    <= r_rd_idx + 1'b1;
                r_addr_hold <= w_issue_addr;
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_num_words <= i_num_words;
                        r_rd_idx    <= '0;
                        r_out_cnt   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (i_gat_ready) begin
                        if (r_num_words == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_state <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (w_issue && (r_rd_idx + 1'b1 == r_num_words)) begin
                        r_state <= StFlush;
                    end
                end
                StFlush: begin
                    if (w_drained) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Read-valid shift pipe matching the BRAM latency.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while the count is zero.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= i_feat_bram_dout;
        end
    end

endmodule

// File: doc/gat_feat_bram_reader.md
Name: gat_feat_bram_reader

Overview:
- Drains the new-feature BRAM once the GAT core reports gat_ready.
- Drives the feature BRAM read port (feat_bram_addrb / feat_bram_dout) with byte addresses, matching the core's word-index slicing [ADDR_W+1:2].
- Re-packs the read data into an AXI-Stream master for the PS/DMA, with full backpressure support.
- Sits beside gat_top_wrapper in the block design, on the host side of the feature BRAM.

Parameters:
- NEW_FEATURE_WIDTH, 32, stream and BRAM data width.
- NUM_FEATURE_OUT, 16, features per subgraph.
- NUM_SUBGRAPHS, 2708, number of subgraph result rows.
- NEW_FEATURE_DEPTH, NUM_SUBGRAPHS*NUM_FEATURE_OUT, number of BRAM words.
- NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), word index width.
- RD_LATENCY, 2, feature BRAM read latency in cycles (1..3).
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to drain.
- num_words  in  NEW_FEATURE_ADDR_W+1  words to read; sampled on an accepted start.
- gat_ready  in  1  core results valid.
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address, equal to word index << 2.
- feat_bram_dout  in  NEW_FEATURE_WIDTH  BRAM read data, valid RD_LATENCY cycles after its address.
- m_axis_tdata  out  NEW_FEATURE_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  asserted on the final word.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low at a clock edge):
  - All outputs are 0; state is IDLE.
  - FIFO, in-flight pipe, and counters are cleared.
  - Reset mid-transfer aborts the transfer; data in flight is discarded and done is not pulsed.
- FSM states:
  - IDLE: start=1 latches num_words into rem_cnt, clears rd_idx and out_cnt, sets busy, goes to WAIT_RDY. start while busy is ignored.
  - WAIT_RDY: holds until gat_ready=1. If num_words==0, goes directly to DONE.
  - ISSUE: issues one read per cycle while credit>0 and rd_idx<num_words.
    - Per read: feat_bram_addrb={rd_idx,2'b00}, rd_idx++, and a valid bit enters a RD_LATENCY-deep shift pipe.
    - When rd_idx reaches num_words, goes to FLUSH.
  - FLUSH: waits until the in-flight pipe and the FIFO are empty and the final beat has been accepted, then goes to DONE.
  - DONE: done=1 for exactly one cycle, busy returns to 0 in the same cycle, next state IDLE.
- Credit rule:
  - credit = FIFO_DEPTH - fifo_count - inflight, evaluated combinationally each cycle.
  - A read is issued only if credit>0, so the FIFO never overflows and no returning word is dropped.
- Data capture: when the pipe tail valid=1, feat_bram_dout is pushed into the FIFO in that cycle.
- Stream output:
  - m_axis_tvalid = FIFO not empty; tdata = FIFO head.
  - A pop happens on tvalid&&tready.
  - Push and pop in the same cycle leave the count unchanged.
  - tdata/tvalid/tlast stay stable while tvalid=1 and tready=0.
- tlast: high when the head is beat number num_words-1. out_cnt is incremented on each pop.
- Address hold: feat_bram_addrb holds its last value when no read is issued. The low 2 bits are always 0.
- gat_ready falling after ISSUE has begun does not stall the transfer; it is only checked in WAIT_RDY.
- Throughput: with tready held at 1, one beat per cycle after an initial latency of RD_LATENCY+1 cycles from the first issue. Back-to-back transfers are allowed with one IDLE cycle between them.
- Width: rd_idx and out_cnt are NEW_FEATURE_ADDR_W+1 bits wide, so num_words = NEW_FEATURE_DEPTH does not wrap.

Test Plan:
- Basic drain: BRAM word i = 0xA5000000+i, num_words=16, gat_ready high, tready=1. Expect 16 beats 0xA5000000..0xA500000F in order, tlast only on beat 15, a single done pulse, and addrb sequence 0x0,0x4,...,0x3C.
- Wait for core: start with gat_ready=0 for 50 cycles. Expect no addrb change, tvalid=0, busy=1; the transfer begins within 1 cycle of gat_ready rising.
- Backpressure: num_words=40, tready toggles randomly at 30% duty. Expect all 40 words in order with no loss or duplication, stable payload while stalled, and fifo_count never above 4.
- Zero length: num_words=0. Expect no BRAM read, no tvalid, and done within 3 cycles of gat_ready.
- Reset abort: rst_n=0 after 7 of 32 beats, then a new start with num_words=8. Expect all outputs 0 during reset and the new stream to begin at word 0 with exactly 8 beats.
- Full depth: num_words=43328 (2708*16), tready=1. Expect the last addrb = 0x2A4FC, tlast on beat 43327, and total cycles ≤ 43328+RD_LATENCY+4.
